// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared op, state and decode constants for the RV32M multiply/divide unit
package ex_mdu_pkg;

  localparam logic [6:0] RV32M_FUNC7 = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_OP_MUL    = 3'b000,
    MDU_OP_MULH   = 3'b001,
    MDU_OP_MULHSU = 3'b010,
    MDU_OP_MULHU  = 3'b011,
    MDU_OP_DIV    = 3'b100,
    MDU_OP_DIVU   = 3'b101,
    MDU_OP_REM    = 3'b110,
    MDU_OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - launch/writeback bundle between execute stage and the multiply/divide unit
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            hold_flag_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_wen_o;

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output busy_o, hold_flag_o, rd_addr_o, rd_data_o, rd_wen_o
  );

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  busy_o, hold_flag_o, rd_addr_o, rd_data_o, rd_wen_o
  );
endinterface

// File: rtl/ex_mdu_div_step.sv
// rtl/ex_mdu_div_step.sv - combinational UNROLL-bit restoring divide step on unsigned magnitudes
module mdu_div_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] q;

  // quo holds the not-yet-consumed dividend bits and fills with quotient bits from the right
  always_comb begin
    r     = rem_i;
    q     = quo_i;
    trial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      trial = {r, q[XLEN-1]};
      q     = {q[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, div_i}) begin
        trial = trial - {1'b0, div_i};
        q[0]  = 1'b1;
      end
      r = trial[XLEN-1:0];
    end
    rem_o = r;
    quo_o = q;
  end
endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - RV32M multi-cycle multiply/divide execute unit
// Divider datapath and ops 100-111 are built only when MDU_DIV_EN is defined.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave bus
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  mdu_state_e      state_q, state_d;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, mcand_q;
  logic [CW-1:0]   cnt_q;

  logic            accept, fast, s1, s2, wen_ok;
  logic [XLEN-1:0] mag1, mag2, hi_d, lo_d;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] mul_hi, mul_lo, res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    s1   = bus.op1_i[XLEN-1] & (bus.op_i inside {MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_DIV, MDU_OP_REM});
    s2   = bus.op2_i[XLEN-1] & (bus.op_i inside {MDU_OP_MULH, MDU_OP_DIV, MDU_OP_REM});
    mag1 = s1 ? -bus.op1_i : bus.op1_i;
    mag2 = s2 ? -bus.op2_i : bus.op2_i;
  end

`ifdef MDU_DIV_EN
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] div_hi, div_lo, sel;

  always_comb begin
    div_zero = bus.op_i[2] & (bus.op2_i == '0);
    div_ovf  = ((bus.op_i == MDU_OP_DIV) || (bus.op_i == MDU_OP_REM)) &&
               (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2_i == '1);
    fast     = div_zero | div_ovf;
  end

  mdu_div_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_div_step (
    .rem_i(hi_q),
    .quo_i(lo_q),
    .div_i(mcand_q),
    .rem_o(div_hi),
    .quo_o(div_lo)
  );

  assign hi_d   = op_q[2] ? div_hi : mul_hi;
  assign lo_d   = op_q[2] ? div_lo : mul_lo;
  assign wen_ok = 1'b1;
`else
  assign fast   = bus.op_i[2];
  assign hi_d   = mul_hi;
  assign lo_d   = mul_lo;
  assign wen_ok = ~op_q[2];
`endif

  assign accept = (state_q == MDU_IDLE) & bus.start_i & ~bus.flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (accept) state_d = fast ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (cnt_q == CW'(1)) state_d = MDU_DONE;
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (bus.flush_i) state_d = MDU_IDLE;
  end

  // Shift-add: lo starts as the multiplier and is consumed from bit 0 as product bits shift in
  always_comb begin
    mul_hi = hi_q;
    mul_lo = lo_q;
    sum    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      sum    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand_q} : '0);
      mul_lo = {sum[0], mul_lo[XLEN-1:1]};
      mul_hi = sum[XLEN:1];
    end
  end

  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_q) prod = -prod;
    res = (op_q == MDU_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    sel = op_q[1] ? hi_q : lo_q;
    if (op_q[2]) res = neg_q ? -sel : sel;
`else
    if (op_q[2]) res = '0;
`endif
  end

  always_comb begin
    bus.busy_o      = (state_q != MDU_IDLE);
    bus.hold_flag_o = accept | (state_q == MDU_CALC);
    bus.rd_wen_o    = (state_q == MDU_DONE) & (rd_q != 5'd0) & ~bus.flush_i & wen_ok;
    bus.rd_data_o   = (state_q == MDU_DONE) ? res : '0;
    bus.rd_addr_o   = (state_q == MDU_DONE) ? rd_q : 5'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op_i;
        rd_q    <= bus.rd_addr_i;
        cnt_q   <= N_CNT;
        hi_q    <= '0;
        lo_q    <= mag2;
        mcand_q <= mag1;
        neg_q   <= s1 ^ s2;
`ifdef MDU_DIV_EN
        // Fast cases preload {remainder, quotient} so the common result mux serves them
        if (bus.op_i[2]) begin
          lo_q    <= mag1;
          mcand_q <= mag2;
          neg_q   <= bus.op_i[1] ? s1 : (s1 ^ s2);
          if (div_zero) begin
            hi_q  <= bus.op1_i;
            lo_q  <= '1;
            neg_q <= 1'b0;
          end else if (div_ovf) begin
            lo_q  <= bus.op1_i;
            neg_q <= 1'b0;
          end
        end
`endif
      end else if (state_q == MDU_CALC) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

- Parametrised multi-cycle multiply/divide execute unit implementing the RV32M `func3` operations.
- Sits beside the single-cycle execute ALU. Takes operands for `opcode` `INST_TYPE_R_M` with `func7 == 7'b0000001`.
- Stalls the pipeline through `hold_flag_o` to ctrl while it iterates.
- Returns `rd_addr_o`/`rd_data_o`/`rd_wen_o` to regs as a one-cycle write pulse.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `UNROLL`, 1: result bits retired per iteration cycle. Must divide `XLEN`. Iteration count `N = XLEN/UNROLL`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  launch operation. Sampled only in IDLE.
- `op_i`  in  3  `func3`: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1_i`  in  XLEN  rs1 value.
- `op2_i`  in  XLEN  rs2 value.
- `rd_addr_i`  in  5  destination register.
- `flush_i`  in  1  jump from ctrl. Aborts the operation.
- `busy_o`  out  1  state ≠ IDLE.
- `hold_flag_o`  out  1  pipeline stall request to ctrl.
- `rd_addr_o`  out  5  destination register.
- `rd_data_o`  out  XLEN  result.
- `rd_wen_o`  out  1  one-cycle write strobe.

## Operation
States and transitions:
- IDLE → CALC: `start_i & ~flush_i`.
- IDLE → DONE: the start is a fast case (see below).
- CALC → DONE: after N iterations.
- DONE → IDLE: unconditionally.
- Any state → IDLE: `flush_i`.

On accept, latch op, `rd_addr_i`, operand magnitudes and sign flags. Counter loads N.

Multiply:
- Shift-add on magnitudes into a 2·XLEN accumulator.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `op1` signed, `op2` unsigned.
  - MULHU, MUL: both unsigned (MUL's low half is sign-independent).
- Product is negated when the operand signs differ.
- MUL returns the low XLEN bits; the others return the high XLEN bits.

Divide:
- Restoring division on magnitudes, `UNROLL` quotient bits per cycle.
- DIV: quotient negated when the signs differ.
- REM: remainder takes the dividend's sign.
- DIVU/REMU: no sign handling.

Fast cases (no iteration, IDLE → DONE):
- Divisor 0: quotient all-ones, remainder = dividend.
- Signed overflow (`op1 = 2^(XLEN-1)`, `op2 = -1`): quotient = dividend, remainder 0.

Output rules:
- `rd_wen_o = 1` only in DONE, and only when the latched `rd_addr ≠ 0`.
- `rd_data_o`/`rd_addr_o` are valid only in DONE and are zero otherwise.
- `start_i` while busy is ignored.
- `flush_i` beats `start_i` in the same cycle.
- A flush in DONE suppresses `rd_wen_o` (the gating is combinational).

## Timing
- Reset: state IDLE; all outputs 0; accumulator and counter 0.
- Normal latency: start accepted at cycle 0 → CALC during cycles 1..N → DONE at cycle N+1 (`rd_wen_o` high for exactly one cycle). XLEN=32, UNROLL=1 gives DONE at cycle 33.
- Fast-case latency: DONE at cycle 1.
- `hold_flag_o = (IDLE & start_i & ~flush_i) | CALC`. It is combinational from `start_i`, so the launching instruction stalls in the same cycle. It is low in DONE so the pipeline advances with the write.
- `busy_o` is registered-state-derived and high in CALC and DONE.
- Back-to-back operations: a new start is accepted earliest in the first IDLE cycle after DONE.
- Reset mid-operation: asynchronous. Outputs clear immediately and no write is issued.

## Configuration
Macro `MDU_DIV_EN`.
- Defined: the divider datapath and ops 100–111 are implemented as above.
- Undefined:
  - The divider is not built.
  - Ops 100–111 go IDLE → DONE with `rd_data_o = 0` and `rd_wen_o = 0`.
  - Multiply behaviour is unchanged.

## Structure
- Shared package holds:
  - Op encodings `MDU_OP_MUL` … `MDU_OP_REMU`.
  - State encoding `MDU_IDLE`/`MDU_CALC`/`MDU_DONE`.
  - The `RV32M_FUNC7` constant.
- Sub-module `mdu_div_step`: combinational `UNROLL`-bit restoring-divide step (partial remainder and quotient bits out). Instantiated only under `MDU_DIV_EN`.
- Multiply iteration stays inline.

## Test plan
1. MUL 7 × 0xFFFFFFFD → `rd_data_o = 0xFFFFFFEB`, `rd_wen_o` pulses at cycle 33. `hold_flag_o` is high in cycles 0–32 and low at cycle 33.
2. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
4. DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0. All reach DONE at cycle 1.
5. Start MUL, assert `flush_i` at cycle 10 → IDLE at cycle 11, no `rd_wen_o`. A `start_i` asserted together with `flush_i` in IDLE is not accepted.
6. Assert `rst` at cycle 15 of a DIV → all outputs 0 immediately and `busy_o = 0`. Then MUL with `rd_addr_i = 0` → DONE at cycle 33 with `rd_wen_o = 0`.
